// File: rtl/mmio_bus_ctrl_if.sv
// mmio_bus_ctrl_if: the CPU-side request/ready bus, the RAM port and the
// keyboard receiver push port, bundled for the MMIO controller.
// The slave modport is the controller's view; master is the surrounding system.
interface mmio_bus_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int RAM_AW = 7
);
    logic              cpu_req;
    logic              cpu_wr;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_ready;
    logic              cpu_err;
    logic              ram_we;
    logic [RAM_AW-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic              kbd_valid;
    logic [7:0]        kbd_code;

    modport slave (
        input  cpu_req, cpu_wr, cpu_addr, cpu_wdata, ram_rdata, kbd_valid, kbd_code,
        output cpu_rdata, cpu_ready, cpu_err, ram_we, ram_addr, ram_wdata
    );

    modport master (
        output cpu_req, cpu_wr, cpu_addr, cpu_wdata, ram_rdata, kbd_valid, kbd_code,
        input  cpu_rdata, cpu_ready, cpu_err, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/mmio_bus_ctrl.sv
// mmio_bus_ctrl: registered request/ready MMIO controller in front of the
// data RAM (with configurable wait states), a keyboard scan-code FIFO with
// DATA/STATUS registers, and an error response for unmapped addresses.
// Optional feature macro: MMIO_KBD_IRQ_EN adds the kbd_irq output and the
// irq-enable bit (STATUS bit3).
module mmio_bus_ctrl #(
    parameter int          DATA_W    = 32,
    parameter int          ADDR_W    = 32,
    parameter int          MEM_BYTES = 512,
    parameter int          RAM_WAIT  = 1,
    parameter logic [31:0] KBD_BASE  = 32'h0000_0200,
    parameter int          KBD_DEPTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    mmio_bus_ctrl_if.slave bus
`ifdef MMIO_KBD_IRQ_EN
    ,
    output logic           kbd_irq
`endif
);

    localparam int RAM_AW = $clog2(MEM_BYTES) - 2;
    localparam int PTR_W  = $clog2(KBD_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    localparam logic [ADDR_W-1:0] MEM_LIMIT  = ADDR_W'(MEM_BYTES);
    localparam logic [ADDR_W-1:0] KBD_DATA_A = ADDR_W'(KBD_BASE);
    localparam logic [ADDR_W-1:0] KBD_STAT_A = ADDR_W'(KBD_BASE + 32'd4);
    localparam logic [CNT_W-1:0]  FIFO_FULL  = CNT_W'(KBD_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        RAM_ACC,
        RESP
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          waitCnt_q, waitCnt_d;
    logic [RAM_AW-1:0]   ramAddr_q, ramAddr_d;
    logic [DATA_W-1:0]   ramWdata_q, ramWdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                isWrite_q, isWrite_d;
    logic                err_q, err_d;

    logic [7:0]          kbdMem_q [KBD_DEPTH];
    logic [PTR_W-1:0]    wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]    rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                overflow_q, overflow_d;

`ifdef MMIO_KBD_IRQ_EN
    logic                irqEn_q, irqEn_d;
    logic                kbdIrq_q;
`endif

    logic [ADDR_W-1:0]   wordAddr;
    logic                ramHit;
    logic                kbdDataHit;
    logic                kbdStatHit;
    logic                fifoEmpty;
    logic                fifoFull;
    logic                popReq;
    logic                pushOk;
    logic                ovfClear;
    logic [DATA_W-1:0]   statusWord;

    assign wordAddr   = {bus.cpu_addr[ADDR_W-1:2], 2'b00};
    assign ramHit     = bus.cpu_addr < MEM_LIMIT;
    assign kbdDataHit = (wordAddr == KBD_DATA_A);
    assign kbdStatHit = (wordAddr == KBD_STAT_A);
    assign fifoEmpty  = (count_q == '0);
    assign fifoFull   = (count_q == FIFO_FULL);

    // Assemble the STATUS register view from the live FIFO state.
    always_comb begin
        statusWord       = '0;
        statusWord[0]    = fifoEmpty;
        statusWord[1]    = fifoFull;
        statusWord[2]    = overflow_q;
`ifdef MMIO_KBD_IRQ_EN
        statusWord[3]    = irqEn_q;
`endif
        statusWord[15:8] = 8'(count_q);
    end

    // Access FSM: decode in IDLE, count RAM wait states, then give one ready cycle.
    always_comb begin
        state_d    = state_q;
        waitCnt_d  = waitCnt_q;
        ramAddr_d  = ramAddr_q;
        ramWdata_d = ramWdata_q;
        rdata_d    = rdata_q;
        isWrite_d  = isWrite_q;
        err_d      = err_q;
        popReq     = 1'b0;
        ovfClear   = 1'b0;
`ifdef MMIO_KBD_IRQ_EN
        irqEn_d    = irqEn_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.cpu_req) begin
                    isWrite_d = bus.cpu_wr;
                    err_d     = 1'b0;
                    rdata_d   = '0;
                    if (ramHit) begin
                        state_d   = RAM_ACC;
                        waitCnt_d = 4'(RAM_WAIT);
                        ramAddr_d = bus.cpu_addr[RAM_AW+1:2];
                        if (bus.cpu_wr) begin
                            ramWdata_d = bus.cpu_wdata;
                        end
                    end else if (kbdDataHit) begin
                        state_d = RESP;
                        if (!bus.cpu_wr && !fifoEmpty) begin
                            rdata_d = DATA_W'(kbdMem_q[rdPtr_q]);
                            popReq  = 1'b1;
                        end
                    end else if (kbdStatHit) begin
                        state_d = RESP;
                        if (!bus.cpu_wr) begin
                            rdata_d = statusWord;
                        end else begin
                            ovfClear = bus.cpu_wdata[2];
`ifdef MMIO_KBD_IRQ_EN
                            irqEn_d  = bus.cpu_wdata[3];
`endif
                        end
                    end else begin
                        state_d = RESP;
                        err_d   = 1'b1;
                    end
                end
            end
            RAM_ACC: begin
                if (waitCnt_q == 4'd0) begin
                    state_d = RESP;
                    if (!isWrite_q) begin
                        rdata_d = bus.ram_rdata;
                    end
                end else begin
                    waitCnt_d = waitCnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FIFO bookkeeping: a pop frees a slot in the same cycle, so a push into a
    // full FIFO alongside a pop is accepted; overflow set beats a clear.
    always_comb begin
        wrPtr_d    = wrPtr_q;
        rdPtr_d    = rdPtr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        pushOk     = bus.kbd_valid && (!fifoFull || popReq);
        if (pushOk) begin
            wrPtr_d = wrPtr_q + PTR_W'(1);
        end
        if (popReq) begin
            rdPtr_d = rdPtr_q + PTR_W'(1);
        end
        case ({pushOk, popReq})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (ovfClear) begin
            overflow_d = 1'b0;
        end
        if (bus.kbd_valid && fifoFull && !popReq) begin
            overflow_d = 1'b1;
        end
    end

    // State and datapath registers; reset abandons any access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            waitCnt_q  <= '0;
            ramAddr_q  <= '0;
            ramWdata_q <= '0;
            rdata_q    <= '0;
            isWrite_q  <= 1'b0;
            err_q      <= 1'b0;
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            waitCnt_q  <= waitCnt_d;
            ramAddr_q  <= ramAddr_d;
            ramWdata_q <= ramWdata_d;
            rdata_q    <= rdata_d;
            isWrite_q  <= isWrite_d;
            err_q      <= err_d;
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Scan-code storage; contents need no reset because the count gates reads.
    always_ff @(posedge clk) begin
        if (pushOk) begin
            kbdMem_q[wrPtr_q] <= bus.kbd_code;
        end
    end

`ifdef MMIO_KBD_IRQ_EN
    // Interrupt request: pending codes or overflow, gated by the enable bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irqEn_q  <= 1'b1;
            kbdIrq_q <= 1'b0;
        end else begin
            irqEn_q  <= irqEn_d;
            kbdIrq_q <= irqEn_d && ((count_d != '0) || overflow_d);
        end
    end

    assign kbd_irq = kbdIrq_q;
`endif

    assign bus.cpu_ready = (state_q == RESP);
    assign bus.cpu_err   = err_q && (state_q == RESP);
    assign bus.cpu_rdata = rdata_q;
    assign bus.ram_we    = (state_q == RAM_ACC) && (waitCnt_q == 4'd0) && isWrite_q;
    assign bus.ram_addr  = ramAddr_q;
    assign bus.ram_wdata = ramWdata_q;

endmodule

// File: tb/tb_mmio_bus_ctrl.sv
// tb_mmio_bus_ctrl: self-checking bench for mmio_bus_ctrl with a RAM model,
// a queue-based keyboard FIFO model and an expected-memory image.
module tb_mmio_bus_ctrl;

    localparam int          DATA_W    = 32;
    localparam int          ADDR_W    = 32;
    localparam int          MEM_BYTES = 512;
    localparam int          RAM_WAIT  = 1;
    localparam int          KBD_DEPTH = 8;
    localparam int          RAM_AW    = 7;
    localparam logic [31:0] KBD_BASE  = 32'h0000_0200;
    localparam int          LAT_RAM   = RAM_WAIT + 2;

    logic clk = 1'b0;
    logic rst;

    int checks = 0;
    int errors = 0;

    logic [31:0] ramMem [0:127];
    logic [31:0] expMem [0:127];
    logic [7:0]  kq [$];
    bit          ovf;
    int          weCount = 0;
    int          readyCount = 0;
    logic [6:0]  lastWeAddr;
    logic [31:0] lastWeData;

    always #5 clk = ~clk;

    mmio_bus_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RAM_AW(RAM_AW)) bus ();

    mmio_bus_ctrl #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_BYTES(MEM_BYTES),
        .RAM_WAIT(RAM_WAIT), .KBD_BASE(KBD_BASE), .KBD_DEPTH(KBD_DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    assign bus.ram_rdata = ramMem[bus.ram_addr];

    // RAM device and bus monitors, sampled mid-cycle
    always @(negedge clk) begin
        if (bus.ram_we === 1'b1) begin
            weCount++;
            lastWeAddr = bus.ram_addr;
            lastWeData = bus.ram_wdata;
            ramMem[bus.ram_addr] = bus.ram_wdata;
        end
        if (bus.cpu_ready === 1'b1) readyCount++;
    end

    function automatic logic [31:0] expStatus();
        logic [31:0] s;
        s = '0;
        s[15:8] = 8'(kq.size());
        s[2] = ovf;
        s[1] = (kq.size() == KBD_DEPTH);
        s[0] = (kq.size() == 0);
        return s;
    endfunction

    function automatic logic [31:0] modelKbdRead();
        if (kq.size() == 0) return 32'h0;
        return {24'h0, kq.pop_front()};
    endfunction

    task automatic pushCode(input logic [7:0] c);
        bus.kbd_valid = 1'b1;
        bus.kbd_code  = c;
        @(posedge clk); #1;
        bus.kbd_valid = 1'b0;
        if (kq.size() < KBD_DEPTH) kq.push_back(c);
        else ovf = 1'b1;
    endtask

    task automatic doAccess(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input bit pushWith, input logic [7:0] pcode,
                            output logic [31:0] rd, output logic er, output int lat);
        bus.cpu_req   = 1'b1;
        bus.cpu_wr    = wr;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wdata;
        if (pushWith) begin
            bus.kbd_valid = 1'b1;
            bus.kbd_code  = pcode;
        end
        rd = '0; er = 1'b0; lat = 0;
        @(posedge clk); #1;
        bus.kbd_valid = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (bus.cpu_ready === 1'b1) begin
                lat = n; rd = bus.cpu_rdata; er = bus.cpu_err;
                break;
            end
        end
        if (lat == 0) begin
            checks++; errors++;
            $display("[TB] FAIL access_timeout addr=%h got no ready in 40 cycles, required ready", addr);
        end
        @(posedge clk); #1;
        bus.cpu_req = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] rd; logic er; int lat;
        rst = 1'b1;
        bus.cpu_req = 0; bus.cpu_wr = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.kbd_valid = 0; bus.kbd_code = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.cpu_ready !== 1'b0 || bus.cpu_err !== 1'b0 || bus.cpu_rdata !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_cpu_outputs got ready=%b err=%b rdata=%h, required 0 0 0",
                     bus.cpu_ready, bus.cpu_err, bus.cpu_rdata);
        end
        checks++;
        if (bus.ram_we !== 1'b0 || bus.ram_addr !== 7'd0 || bus.ram_wdata !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_ram_outputs got we=%b addr=%h wdata=%h, required 0 0 0",
                     bus.ram_we, bus.ram_addr, bus.ram_wdata);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        doAccess(0, KBD_BASE + 32'd4, 0, 0, 0, rd, er, lat);
        checks++;
        if (rd !== 32'h1 || er !== 1'b0 || lat !== 1) begin
            errors++;
            $display("[TB] FAIL reset_status got rdata=%h err=%b lat=%0d, required 00000001 0 1", rd, er, lat);
        end
    endtask

    task automatic test_ram_basic();
        logic [31:0] rd; logic er; int lat; int w0; int r0;
        w0 = weCount;
        doAccess(1, 32'h10, 32'hDEADBEEF, 0, 0, rd, er, lat);
        expMem[4] = 32'hDEADBEEF;
        checks++;
        if (weCount - w0 !== 1 || lastWeAddr !== 7'd4 || lastWeData !== 32'hDEADBEEF) begin
            errors++;
            $display("[TB] FAIL ram_write_strobe got pulses=%0d addr=%0d data=%h, required 1 4 deadbeef",
                     weCount - w0, lastWeAddr, lastWeData);
        end
        checks++;
        if (lat !== LAT_RAM || er !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ram_write_latency got lat=%0d err=%b, required %0d 0", lat, er, LAT_RAM);
        end
        w0 = weCount;
        r0 = readyCount;
        doAccess(0, 32'h10, 32'h0, 0, 0, rd, er, lat);
        @(negedge clk);
        checks++;
        if (rd !== 32'hDEADBEEF || er !== 1'b0 || lat !== LAT_RAM || weCount !== w0) begin
            errors++;
            $display("[TB] FAIL ram_read got rdata=%h err=%b lat=%0d wepulses=%0d, required deadbeef 0 %0d 0",
                     rd, er, lat, weCount - w0, LAT_RAM);
        end
        checks++;
        if (readyCount - r0 !== 1) begin
            errors++;
            $display("[TB] FAIL ready_single_cycle got %0d ready cycles, required 1", readyCount - r0);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_kbd_basic();
        logic [31:0] rd; logic [31:0] exp; logic er; int lat;
        pushCode(8'h1C);
        pushCode(8'h2A);
        for (int i = 0; i < 3; i++) begin
            exp = modelKbdRead();
            doAccess(0, KBD_BASE, 0, 0, 0, rd, er, lat);
            checks++;
            if (rd !== exp || er !== 1'b0 || lat !== 1) begin
                errors++;
                $display("[TB] FAIL kbd_data_read%0d got rdata=%h err=%b lat=%0d, required %h 0 1", i, rd, er, lat, exp);
            end
        end
        doAccess(0, KBD_BASE + 32'd4, 0, 0, 0, rd, er, lat);
        checks++;
        if (rd !== 32'h1) begin
            errors++;
            $display("[TB] FAIL kbd_status_empty got %h, required 00000001", rd);
        end
    endtask

    task automatic test_kbd_overflow();
        logic [31:0] rd; logic [31:0] exp; logic er; int lat;
        for (int i = 0; i < 9; i++) pushCode(8'($urandom));
        doAccess(0, KBD_BASE + 32'd4, 0, 0, 0, rd, er, lat);
        checks++;
        if (rd !== 32'h0806) begin
            errors++;
            $display("[TB] FAIL status_overflow got %h, required 00000806", rd);
        end
        doAccess(1, KBD_BASE + 32'd4, 32'h4, 0, 0, rd, er, lat);
        ovf = 1'b0;
        doAccess(0, KBD_BASE + 32'd4, 0, 0, 0, rd, er, lat);
        checks++;
        if (rd !== 32'h0802) begin
            errors++;
            $display("[TB] FAIL status_ovf_cleared got %h, required 00000802", rd);
        end
        for (int i = 0; i < 8; i++) begin
            exp = modelKbdRead();
            doAccess(0, KBD_BASE, 0, 0, 0, rd, er, lat);
            checks++;
            if (rd !== exp) begin
                errors++;
                $display("[TB] FAIL overflow_drain%0d got %h, required %h", i, rd, exp);
            end
        end
    endtask

    task automatic test_push_pop_same();
        logic [31:0] rd; logic [31:0] exp; logic er; int lat; logic [7:0] newc;
        for (int i = 0; i < KBD_DEPTH; i++) pushCode(8'($urandom));
        newc = 8'($urandom);
        exp = modelKbdRead();
        kq.push_back(newc);
        doAccess(0, KBD_BASE, 0, 1, newc, rd, er, lat);
        checks++;
        if (rd !== exp) begin
            errors++;
            $display("[TB] FAIL pushpop_data got %h, required %h", rd, exp);
        end
        doAccess(0, KBD_BASE + 32'd4, 0, 0, 0, rd, er, lat);
        checks++;
        if (rd !== 32'h0802) begin
            errors++;
            $display("[TB] FAIL pushpop_status got %h, required 00000802", rd);
        end
        for (int i = 0; i < KBD_DEPTH; i++) begin
            exp = modelKbdRead();
            doAccess(0, KBD_BASE, 0, 0, 0, rd, er, lat);
            checks++;
            if (rd !== exp) begin
                errors++;
                $display("[TB] FAIL pushpop_drain%0d got %h, required %h", i, rd, exp);
            end
        end
        checks++;
        if (rd !== {24'h0, newc}) begin
            errors++;
            $display("[TB] FAIL pushpop_last got %h, required %h", rd, {24'h0, newc});
        end
    endtask

    task automatic test_unmapped();
        logic [31:0] rd; logic [31:0] addr; logic er; int lat; int w0;
        pushCode(8'h55);
        w0 = weCount;
        doAccess(0, 32'h0000_1000, 0, 0, 0, rd, er, lat);
        checks++;
        if (er !== 1'b1 || rd !== 32'h0 || lat !== 1 || weCount !== w0) begin
            errors++;
            $display("[TB] FAIL unmapped_1000 got err=%b rdata=%h lat=%0d wepulses=%0d, required 1 0 1 0",
                     er, rd, lat, weCount - w0);
        end
        doAccess(1, KBD_BASE, 32'hFF, 0, 0, rd, er, lat);
        checks++;
        if (er !== 1'b0 || lat !== 1) begin
            errors++;
            $display("[TB] FAIL kbd_data_write got err=%b lat=%0d, required 0 1", er, lat);
        end
        for (int i = 0; i < 6; i++) begin
            addr = (i < 3) ? 32'h208 + 32'($urandom_range(0, 32'hFFF)) : ($urandom | 32'h8000_0000);
            w0 = weCount;
            doAccess(i[0], addr, $urandom, 0, 0, rd, er, lat);
            checks++;
            if (er !== 1'b1 || rd !== 32'h0 || lat !== 1 || weCount !== w0) begin
                errors++;
                $display("[TB] FAIL unmapped_rand addr=%h got err=%b rdata=%h lat=%0d, required 1 0 1",
                         addr, er, rd, lat);
            end
        end
        doAccess(0, KBD_BASE + 32'd4, 0, 0, 0, rd, er, lat);
        checks++;
        if (rd !== expStatus()) begin
            errors++;
            $display("[TB] FAIL unmapped_fifo_status got %h, required %h", rd, expStatus());
        end
        void'(modelKbdRead());
        doAccess(0, KBD_BASE, 0, 0, 0, rd, er, lat);
        checks++;
        if (rd !== 32'h55) begin
            errors++;
            $display("[TB] FAIL unmapped_fifo_data got %h, required 00000055", rd);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic [31:0] d; logic er; int lat;
        for (int i = 0; i < 6; i++) begin
            d = $urandom;
            expMem[64 + i] = d;
            doAccess(1, 32'h100 + 32'(4 * i), d, 0, 0, rd, er, lat);
        end
        for (int i = 0; i < 6; i++) begin
            doAccess(0, 32'h100 + 32'(4 * i), 0, 0, 0, rd, er, lat);
            checks++;
            if (rd !== expMem[64 + i] || lat !== LAT_RAM) begin
                errors++;
                $display("[TB] FAIL b2b_read%0d got %h lat=%0d, required %h %0d", i, rd, lat, expMem[64 + i], LAT_RAM);
            end
        end
    endtask

    task automatic test_random_mix();
        logic [31:0] rd; logic [31:0] addr; logic [31:0] wd; logic [31:0] expRd; logic er;
        int lat; int op; int w0; int expLat; int expWe; bit expErr; bit wr; bit chkRd;
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 9) < 3) begin
                for (int k = 0; k < int'($urandom_range(1, 3)); k++) pushCode(8'($urandom));
            end
            op = $urandom_range(0, 5);
            wd = $urandom;
            expRd = 32'h0; chkRd = 1'b1; expErr = 1'b0; expLat = 1; expWe = 0; wr = 1'b0;
            case (op)
                0: begin addr = $urandom_range(0, MEM_BYTES - 1); wr = 1'b1; chkRd = 1'b0;
                         expLat = LAT_RAM; expWe = 1; end
                1: begin addr = $urandom_range(0, MEM_BYTES - 1); expLat = LAT_RAM;
                         expRd = expMem[addr[8:2]]; end
                2: begin addr = KBD_BASE + 32'($urandom_range(0, 3)); expRd = modelKbdRead(); end
                3: begin addr = KBD_BASE + 32'd4; expRd = expStatus(); end
                4: begin addr = KBD_BASE + 32'd4; wr = 1'b1; chkRd = 1'b0;
                         if (wd[2]) ovf = 1'b0; end
                default: begin addr = 32'h400 + 32'($urandom_range(0, 32'hFFFF)); wr = $urandom_range(0, 1);
                         expErr = 1'b1; end
            endcase
            w0 = weCount;
            doAccess(wr, addr, wd, 0, 0, rd, er, lat);
            if (op == 0) expMem[addr[8:2]] = wd;
            checks++;
            if ((chkRd && rd !== expRd) || er !== expErr || lat !== expLat || (weCount - w0) !== expWe ||
                (op == 0 && (lastWeAddr !== addr[8:2] || lastWeData !== wd))) begin
                errors++;
                $display("[TB] FAIL mix%0d op=%0d addr=%h got rdata=%h err=%b lat=%0d we=%0d, required %h %b %0d %0d",
                         it, op, addr, rd, er, lat, weCount - w0, expRd, expErr, expLat, expWe);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic er; int lat; int w0; int r0;
        pushCode(8'h77);
        w0 = weCount;
        r0 = readyCount;
        bus.cpu_req = 1'b1; bus.cpu_wr = 1'b1; bus.cpu_addr = 32'h40; bus.cpu_wdata = 32'h1234_5678;
        @(posedge clk); #1;
        rst = 1'b1;
        bus.cpu_req = 1'b0;
        kq.delete();
        ovf = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.ram_addr !== 7'd0 || bus.ram_wdata !== 32'h0 || bus.cpu_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_outputs got addr=%h wdata=%h ready=%b, required 0 0 0",
                     bus.ram_addr, bus.ram_wdata, bus.cpu_ready);
        end
        repeat (2) @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk); #1;
        checks++;
        if (weCount !== w0 || readyCount !== r0) begin
            errors++;
            $display("[TB] FAIL midreset_abandon got wepulses=%0d readys=%0d, required 0 0", weCount - w0, readyCount - r0);
        end
        doAccess(0, KBD_BASE + 32'd4, 0, 0, 0, rd, er, lat);
        checks++;
        if (rd !== 32'h1) begin
            errors++;
            $display("[TB] FAIL midreset_fifo got status %h, required 00000001", rd);
        end
        doAccess(0, 32'h40, 0, 0, 0, rd, er, lat);
        checks++;
        if (rd !== expMem[16] || er !== 1'b0 || lat !== LAT_RAM) begin
            errors++;
            $display("[TB] FAIL midreset_ram_read got %h err=%b lat=%0d, required %h 0 %0d", rd, er, lat, expMem[16], LAT_RAM);
        end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) begin
            ramMem[i] = 32'h0;
            expMem[i] = 32'h0;
        end
        ovf = 1'b0;
        test_reset();
        test_ram_basic();
        test_kbd_basic();
        test_kbd_overflow();
        test_push_pop_same();
        test_unmapped();
        test_back_to_back();
        test_random_mix();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog got no completion, required finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
